microsequencer_fetch: RTL
=========================

Name: microsequencer_fetch

Overview:
- First stage of the microprogrammed pipeline.
- Holds the microprogram counter (MPC) and a writable control store.
- Each cycle it fetches one microword, registers it into microinstruction register 1, and drives the ALU/SH/C/T fields straight into the second microinstruction stage.
- Next-address logic resolves sequential, conditional (N/Z flag) and unconditional jumps with zero delay slots.

Parameters:
- ADDR_W, 8, MPC and control-store address width.
- DEPTH, 256, control-store words (must equal 2**ADDR_W).
- START_ADDR, 0, MPC value loaded on reset and on start.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins execution from START_ADDR.
- n_flag  in  1  ALU negative flag fed back from downstream.
- z_flag  in  1  ALU zero flag fed back from downstream.
- wr_en  in  1  control-store write strobe.
- wr_addr  in  ADDR_W  control-store write address.
- wr_data  in  29  microword {ALU[28:25], SH[24:23], C[22:17], T[16:10], COND[9:8], ADDR[7:0]}.
- ALU_out  out  4  ALU field of the registered microword.
- SH_out  out  2  shifter field.
- C_out  out  6  C-bus field.
- T_out  out  7  T field.
- valid_out  out  1  high when the ALU/SH/C/T outputs carry a fetched microword.
- mpc_out  out  ADDR_W  address of the word currently on the outputs.
- running  out  1  high in state RUN.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State=IDLE, MPC=START_ADDR, mpc_out=0.
  - ALU_out/SH_out/C_out/T_out=0 (NOP), valid_out=0, running=0.
  - Control-store contents are not reset.
- Control store:
  - Register array with combinational read at MPC.
  - Write is synchronous: store[wr_addr] <= wr_data on the clock edge when wr_en=1 and state=IDLE.
  - wr_en in RUN is ignored; contents are unchanged.
- States:
  - IDLE: outputs NOP, valid_out=0. start=1 -> RUN with MPC=START_ADDR. A write and start in the same cycle: the write lands and execution starts.
  - RUN: every cycle:
    - MIR <= store[MPC]; valid_out <= 1; mpc_out <= MPC.
    - MPC <= next address, computed from COND/ADDR of store[MPC] and the flags sampled in that same cycle.
  - start asserted while in RUN: restart; MPC <= START_ADDR on the next edge, and MIR still loads the current word.
- Next address, from the COND field:
  - 00: MPC+1.
  - 01: ADDR if n_flag else MPC+1.
  - 10: ADDR if z_flag else MPC+1.
  - 11: ADDR unconditionally.
- MPC+1 wraps modulo 2**ADDR_W (255 -> 0).
- Halt: a word with COND=11 and ADDR equal to its own address is a halt.
  - The word is issued once with valid_out=1.
  - Next cycle: state -> IDLE, outputs return to NOP, valid_out=0, running=0.
- Latency:
  - start edge -> first microword on outputs: 1 clock.
  - Thereafter one word per clock.
  - Branch taken with no bubble.
- Outputs are registered only; no combinational path from inputs to outputs.
- Reset mid-RUN forces IDLE and NOP immediately (asynchronously).

Optional Feature:
- Macro: MICROSEQ_HOLD_EN.
- Defined: adds input port hold (1 bit).
  - In RUN with hold=1: MPC, MIR, mpc_out and valid_out keep their values; flags are ignored that cycle.
  - start is ignored while hold=1.
  - Halt detection is deferred until hold drops.
- Not defined: no hold port; the sequencer advances every RUN cycle.

Test Plan:
- Load words 0..3 sequential (COND=00), ALU=1,2,3,4; load word 4 as halt (COND=11, ADDR=4); pulse start.
  - Outputs ALU 1,2,3,4 on consecutive cycles with mpc_out 0..3.
  - Then word 4 with valid_out=1, then IDLE (valid_out=0, running=0).
- Word 0 COND=01 ADDR=0x20, n_flag=1 -> next mpc_out=0x20.
- Repeat with n_flag=0 -> next mpc_out=0x01.
- Word 0 COND=10 ADDR=0x40, z_flag=1 -> mpc_out=0x40.
- Word 0xFF with COND=00 -> next mpc_out=0x00 (wrap).
- Write 0x1FFFFFFF to address 5 during RUN -> address 5 unchanged when read back from IDLE.
- Assert reset_n=0 mid-RUN between clock edges -> outputs 0, valid_out=0 before the next edge.
- After release, start re-runs from START_ADDR.
- With MICROSEQ_HOLD_EN defined, hold=1 for 3 cycles at mpc_out=2 -> outputs frozen at word 2.
  - Word 3 appears 1 cycle after hold drops.

Source files
------------

// File: rtl/microsequencer_fetch.sv
// microsequencer_fetch: first pipeline stage; MPC, writable control store, MIR1 and zero-delay-slot next-address logic
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   hold                  freezes the sequencer in RUN (only when MICROSEQ_HOLD_EN is defined)
//   start                 one-cycle pulse, (re)starts execution at START_ADDR
//   n_flag, z_flag        ALU flags used by conditional jumps
//   wr_en/wr_addr/wr_data control-store write port, honoured only in IDLE
//   ALU_out/SH_out/C_out/T_out  registered microword fields
//   valid_out, mpc_out    fields carry a fetched word / its address
//   running               sequencer is in RUN
// Optional feature macro: MICROSEQ_HOLD_EN
module microsequencer_fetch #(
    parameter int ADDR_W = 8,
    parameter int DEPTH = 256,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset_n,
`ifdef MICROSEQ_HOLD_EN
    input  logic              hold,
`endif
    input  logic              start,
    input  logic              n_flag,
    input  logic              z_flag,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [28:0]       wr_data,
    output logic [3:0]        ALU_out,
    output logic [1:0]        SH_out,
    output logic [5:0]        C_out,
    output logic [6:0]        T_out,
    output logic              valid_out,
    output logic [ADDR_W-1:0] mpc_out,
    output logic              running
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic [28:0] store [DEPTH];
    logic [28:0] word;
    logic [18:0] mir;
    logic [ADDR_W-1:0] mpc, mpc_nx, seq_addr, jump_addr;
    logic [1:0] cond;
    logic taken, halt, hold_i;
`ifdef MICROSEQ_HOLD_EN
    assign hold_i = hold;
`else
    assign hold_i = 1'b0;
`endif
    assign word = store[mpc];
    assign cond = word[9:8];
    assign seq_addr = mpc + 1'b1;
    assign jump_addr = ADDR_W'(word[7:0]);
    assign taken = (cond == 2'b11) || (cond == 2'b01 && n_flag) || (cond == 2'b10 && z_flag);
    // a word that jumps unconditionally to itself ends the microprogram
    assign halt = (cond == 2'b11) && (jump_addr == mpc);
    always_comb begin
        state_nx = state;
        mpc_nx = mpc;
        if (state == IDLE) begin
            state_nx = start ? RUN : IDLE;
            mpc_nx = start ? START_ADDR : mpc;
        end else if (!hold_i) begin
            mpc_nx = start ? START_ADDR : taken ? jump_addr : seq_addr;
            state_nx = (halt && !start) ? IDLE : RUN;
        end
    end
    always_ff @(posedge clock) begin
        if (wr_en && state == IDLE) store[wr_addr] <= wr_data;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            mpc <= START_ADDR;
            mir <= '0;
            valid_out <= 1'b0;
            mpc_out <= '0;
        end else begin
            state <= state_nx;
            mpc <= mpc_nx;
            if (state == IDLE) begin
                mir <= '0;
                valid_out <= 1'b0;
                mpc_out <= '0;
            end else if (!hold_i) begin
                mir <= word[28:10];
                valid_out <= 1'b1;
                mpc_out <= mpc;
            end
        end
    end
    assign {ALU_out, SH_out, C_out, T_out} = mir;
    assign running = (state == RUN);
endmodule
